// File: rtl/seq_alu.sv
// Registered ALU with start/busy/done handshake and iterative shift-add multiply.
// Single-cycle ops complete in one clock; MUL takes WIDTH clocks.
module seq_alu #(
    parameter int WIDTH      = 32,
    parameter bit SIGNED_SLT = 1'b1,
    parameter int SHW        = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] hi,
    output logic             eq,
    output logic             ovf,
    output logic             illegal,
    output logic             busy,
    output logic             done
);

    localparam int CW = SHW + 1;
    localparam int H  = WIDTH / 2;

    localparam logic [3:0] OP_MOV  = 4'b0000;
    localparam logic [3:0] OP_NOT  = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SUB  = 4'b0011;
    localparam logic [3:0] OP_OR   = 4'b0100;
    localparam logic [3:0] OP_AND  = 4'b0101;
    localparam logic [3:0] OP_XOR  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_SLTU = 4'b1000;
    localparam logic [3:0] OP_LI   = 4'b1001;
    localparam logic [3:0] OP_SLL  = 4'b1010;
    localparam logic [3:0] OP_SRL  = 4'b1011;
    localparam logic [3:0] OP_SRA  = 4'b1100;
    localparam logic [3:0] OP_MUL  = 4'b1101;

    typedef enum logic {
        S_IDLE,
        S_MUL
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic             eq_q, eq_d;
    logic             ovf_q, ovf_d;
    logic             illegal_q, illegal_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             mul_eq_q, mul_eq_d;

    logic [WIDTH-1:0] sum, diff, alu_res;
    logic [SHW-1:0]   sh;
    logic             lt_s, lt_u, lt_sel;
    logic             alu_ovf, alu_ill;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH-1:0] acc_next, mplier_next;

    always_comb begin
        sum     = a + b;
        diff    = a - b;
        sh      = b[SHW-1:0];
        lt_s    = $signed(a) < $signed(b);
        lt_u    = a < b;
        lt_sel  = SIGNED_SLT ? lt_s : lt_u;
        alu_res = '0;
        alu_ovf = 1'b0;
        alu_ill = 1'b0;
        unique case (op)
            OP_MOV:  alu_res = a;
            OP_NOT:  alu_res = ~a;
            OP_ADD: begin
                alu_res = sum;
                alu_ovf = (a[WIDTH-1] == b[WIDTH-1]) &&
                          (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res = diff;
                alu_ovf = (a[WIDTH-1] != b[WIDTH-1]) &&
                          (diff[WIDTH-1] != a[WIDTH-1]);
            end
            OP_OR:   alu_res = a | b;
            OP_AND:  alu_res = a & b;
            OP_XOR:  alu_res = a ^ b;
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, lt_sel};
            OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, lt_u};
            OP_LI:   alu_res = {{(WIDTH-H){1'b0}}, b[H-1:0]};
            OP_SLL:  alu_res = a << sh;
            OP_SRL:  alu_res = a >> sh;
            OP_SRA:  alu_res = $signed(a) >>> sh;
            OP_MUL:  alu_res = '0;
            default: alu_ill = 1'b1;
        endcase
    end

    // One shift-add step; the carry out of the add lands in acc's top bit.
    always_comb begin
        mul_sum     = {1'b0, acc_q} + (mplier_q[0] ? {1'b0, mcand_q} : '0);
        acc_next    = mul_sum[WIDTH:1];
        mplier_next = {mul_sum[0], mplier_q[WIDTH-1:1]};
    end

    always_comb begin
        state_d   = state_q;
        result_d  = result_q;
        hi_d      = hi_q;
        eq_d      = eq_q;
        ovf_d     = ovf_q;
        illegal_d = illegal_q;
        done_d    = 1'b0;
        acc_d     = acc_q;
        mplier_d  = mplier_q;
        mcand_d   = mcand_q;
        cnt_d     = cnt_q;
        mul_eq_d  = mul_eq_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (op == OP_MUL) begin
                        mcand_d  = a;
                        mplier_d = b;
                        acc_d    = '0;
                        cnt_d    = CW'(WIDTH);
                        mul_eq_d = (a == b);
                        state_d  = S_MUL;
                    end else begin
                        result_d  = alu_res;
                        hi_d      = '0;
                        eq_d      = (a == b);
                        ovf_d     = alu_ovf;
                        illegal_d = alu_ill;
                        done_d    = 1'b1;
                    end
                end
            end
            S_MUL: begin
                acc_d    = acc_next;
                mplier_d = mplier_next;
                cnt_d    = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    result_d  = mplier_next;
                    hi_d      = acc_next;
                    eq_d      = mul_eq_q;
                    ovf_d     = 1'b0;
                    illegal_d = 1'b0;
                    done_d    = 1'b1;
                    state_d   = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            result_q  <= '0;
            hi_q      <= '0;
            eq_q      <= 1'b0;
            ovf_q     <= 1'b0;
            illegal_q <= 1'b0;
            done_q    <= 1'b0;
            acc_q     <= '0;
            mplier_q  <= '0;
            mcand_q   <= '0;
            cnt_q     <= '0;
            mul_eq_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            result_q  <= result_d;
            hi_q      <= hi_d;
            eq_q      <= eq_d;
            ovf_q     <= ovf_d;
            illegal_q <= illegal_d;
            done_q    <= done_d;
            acc_q     <= acc_d;
            mplier_q  <= mplier_d;
            mcand_q   <= mcand_d;
            cnt_q     <= cnt_d;
            mul_eq_q  <= mul_eq_d;
        end
    end

    assign result  = result_q;
    assign hi      = hi_q;
    assign eq      = eq_q;
    assign ovf     = ovf_q;
    assign illegal = illegal_q;
    assign busy    = (state_q == S_MUL);
    assign done    = done_q;

endmodule

// File: tb/tb_seq_alu.sv
// Directed self-checking bench for seq_alu: a 32-bit and an 8-bit instance.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_seq_alu;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [3:0]  op;
    logic [31:0] a, b;
    logic [31:0] result, hi;
    logic        eq, ovf, illegal, busy, done;

    logic        start8;
    logic [3:0]  op8;
    logic [7:0]  a8, b8;
    logic [7:0]  result8, hi8;
    logic        eq8, ovf8, illegal8, busy8, done8;

    int tests_run = 0;
    int fails = 0;

    always #5 clk = ~clk;

    seq_alu #(.WIDTH(32), .SIGNED_SLT(1'b1), .SHW(5)) u_dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .result(result), .hi(hi), .eq(eq), .ovf(ovf), .illegal(illegal),
        .busy(busy), .done(done)
    );

    seq_alu #(.WIDTH(8), .SIGNED_SLT(1'b1), .SHW(3)) u_dut8 (
        .clk(clk), .reset(reset), .start(start8), .op(op8), .a(a8), .b(b8),
        .result(result8), .hi(hi8), .eq(eq8), .ovf(ovf8), .illegal(illegal8),
        .busy(busy8), .done(done8)
    );

    task automatic drive(input logic s, input logic [3:0] o,
                         input logic [31:0] x, input logic [31:0] y);
        start = s;
        op    = o;
        a     = x;
        b     = y;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(1'b1, 4'b0010, 32'd1, 32'd2);
        start8 = 1'b1; op8 = 4'b0010; a8 = 8'd1; b8 = 8'd2;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            tests_run++;
            if ({result, hi, eq, ovf, illegal, busy, done} !== 69'd0) begin
                fails++;
                $display("FAIL reset32 cyc%0d got r=%h hi=%h flags=%b exp all 0",
                         i, result, hi, {eq, ovf, illegal, busy, done});
            end
            tests_run++;
            if ({result8, hi8, eq8, ovf8, illegal8, busy8, done8} !== 21'd0) begin
                fails++;
                $display("FAIL reset8 cyc%0d got r=%h hi=%h exp all 0",
                         i, result8, hi8);
            end
        end
        reset  = 1'b0;
        start8 = 1'b0;
        drive(1'b0, 4'b0000, 32'd0, 32'd0);
    endtask

    task automatic test_add_sub();
        drive(1'b1, 4'b0010, 32'h7FFF_FFFF, 32'h1);
        @(negedge clk);
        tests_run++;
        if (result !== 32'h8000_0000 || ovf !== 1'b1 || done !== 1'b1 || eq !== 1'b0) begin
            fails++;
            $display("FAIL add_ovf got r=%h ovf=%b done=%b eq=%b exp 80000000 1 1 0",
                     result, ovf, done, eq);
        end
        drive(1'b1, 4'b0011, 32'h5, 32'h5);
        @(negedge clk);
        tests_run++;
        if (result !== 32'h0 || eq !== 1'b1 || ovf !== 1'b0 || done !== 1'b1) begin
            fails++;
            $display("FAIL sub_eq got r=%h eq=%b ovf=%b done=%b exp 0 1 0 1",
                     result, eq, ovf, done);
        end
        drive(1'b0, 4'b0010, 32'h1, 32'h2);
        @(negedge clk);
        tests_run++;
        if (done !== 1'b0 || result !== 32'h0 || eq !== 1'b1) begin
            fails++;
            $display("FAIL done_pulse got done=%b r=%h eq=%b exp 0 0 1",
                     done, result, eq);
        end
    endtask

    task automatic test_logic_shift();
        logic [3:0]  ops [6];
        logic [31:0] av  [6];
        logic [31:0] bv  [6];
        logic [31:0] ev  [6];
        ops[0] = 4'b0111; av[0] = 32'hFFFF_FFFF; bv[0] = 32'h1; ev[0] = 32'h1;
        ops[1] = 4'b1000; av[1] = 32'hFFFF_FFFF; bv[1] = 32'h1; ev[1] = 32'h0;
        ops[2] = 4'b1100; av[2] = 32'h8000_0000; bv[2] = 32'h4; ev[2] = 32'hF800_0000;
        ops[3] = 4'b0110; av[3] = 32'hF0F0_F0F0; bv[3] = 32'hFF00_FF00; ev[3] = 32'h0FF0_0FF0;
        ops[4] = 4'b1010; av[4] = 32'h1; bv[4] = 32'h1F; ev[4] = 32'h8000_0000;
        ops[5] = 4'b0001; av[5] = 32'h0000_FFFF; bv[5] = 32'h0; ev[5] = 32'hFFFF_0000;
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, ops[i], av[i], bv[i]);
            @(negedge clk);
            tests_run++;
            if (result !== ev[i] || done !== 1'b1 || illegal !== 1'b0) begin
                fails++;
                $display("FAIL op%b got r=%h done=%b ill=%b exp %h 1 0",
                         ops[i], result, done, illegal, ev[i]);
            end
        end
        drive(1'b1, 4'b1111, 32'h1234, 32'h5678);
        @(negedge clk);
        tests_run++;
        if (result !== 32'h0 || hi !== 32'h0 || illegal !== 1'b1 || done !== 1'b1) begin
            fails++;
            $display("FAIL illegal got r=%h hi=%h ill=%b done=%b exp 0 0 1 1",
                     result, hi, illegal, done);
        end
        drive(1'b1, 4'b0000, 32'hCAFE_BABE, 32'h0);
        @(negedge clk);
        tests_run++;
        if (result !== 32'hCAFE_BABE || illegal !== 1'b0) begin
            fails++;
            $display("FAIL mov_clr_ill got r=%h ill=%b exp cafebabe 0",
                     result, illegal);
        end
        drive(1'b0, 4'b0000, 32'h0, 32'h0);
        @(negedge clk);
    endtask

    task automatic test_mul();
        int busy_cnt = 0;
        int done_cnt = 0;
        int done_at  = -1;
        int overlap  = 0;
        drive(1'b1, 4'b1101, 32'hFFFF_FFFF, 32'h2);
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(negedge clk);
            if (busy === 1'b1) busy_cnt++;
            if (done === 1'b1) begin
                done_cnt++;
                done_at = cyc;
            end
            if (done === 1'b1 && busy === 1'b1) overlap++;
            if (done === 1'b1) begin
                tests_run++;
                if (result !== 32'hFFFF_FFFE || hi !== 32'h1 || eq !== 1'b0 || ovf !== 1'b0) begin
                    fails++;
                    $display("FAIL mul_value got r=%h hi=%h eq=%b ovf=%b exp fffffffe 1 0 0",
                             result, hi, eq, ovf);
                end
            end
            if (cyc < 12)
                drive(1'b1, 4'b0010, 32'd9, 32'd9);
            else
                drive(1'b0, 4'b0010, 32'd0, 32'd0);
        end
        tests_run++;
        if (busy_cnt != 32) begin
            fails++;
            $display("FAIL mul_busy_len got %0d exp 32", busy_cnt);
        end
        tests_run++;
        if (done_cnt != 1 || done_at != 33) begin
            fails++;
            $display("FAIL mul_done got count=%0d at=%0d exp 1 at 33",
                     done_cnt, done_at);
        end
        tests_run++;
        if (overlap != 0) begin
            fails++;
            $display("FAIL mul_done_busy_overlap got %0d exp 0", overlap);
        end
    endtask

    task automatic test_reset_mid_mul();
        int stray = 0;
        drive(1'b1, 4'b1101, 32'h1234, 32'h10);
        @(negedge clk);
        drive(1'b0, 4'b0000, 32'h0, 32'h0);
        for (int i = 0; i < 9; i++) @(negedge clk);
        tests_run++;
        if (busy !== 1'b1) begin
            fails++;
            $display("FAIL mul_busy_pre_reset got %b exp 1", busy);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        tests_run++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== 32'h0 || hi !== 32'h0) begin
            fails++;
            $display("FAIL mul_abort got busy=%b done=%b r=%h hi=%h exp 0 0 0 0",
                     busy, done, result, hi);
        end
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done !== 1'b0 || busy !== 1'b0) stray++;
        end
        tests_run++;
        if (stray != 0) begin
            fails++;
            $display("FAIL mul_abort_quiet got %0d active cycles exp 0", stray);
        end
        drive(1'b1, 4'b0010, 32'd2, 32'd3);
        @(negedge clk);
        drive(1'b0, 4'b0000, 32'h0, 32'h0);
        tests_run++;
        if (result !== 32'd5 || done !== 1'b1 || hi !== 32'h0) begin
            fails++;
            $display("FAIL add_after_abort got r=%h done=%b hi=%h exp 5 1 0",
                     result, done, hi);
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] ops [3];
        logic [7:0] av  [3];
        logic [7:0] bv  [3];
        logic [7:0] ev  [3];
        ops[0] = 4'b0010; av[0] = 8'h03; bv[0] = 8'h04; ev[0] = 8'h07;
        ops[1] = 4'b0100; av[1] = 8'hF0; bv[1] = 8'h0F; ev[1] = 8'hFF;
        ops[2] = 4'b1001; av[2] = 8'h00; bv[2] = 8'hAB; ev[2] = 8'h0B;
        start8 = 1'b1; op8 = ops[0]; a8 = av[0]; b8 = bv[0];
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (i < 2) begin
                op8 = ops[i+1]; a8 = av[i+1]; b8 = bv[i+1];
            end else begin
                start8 = 1'b0;
            end
            tests_run++;
            if (result8 !== ev[i] || done8 !== 1'b1) begin
                fails++;
                $display("FAIL b2b8_%0d got r=%h done=%b exp %h 1",
                         i, result8, done8, ev[i]);
            end
        end
        @(negedge clk);
        tests_run++;
        if (done8 !== 1'b0 || result8 !== 8'h0B) begin
            fails++;
            $display("FAIL b2b8_end got done=%b r=%h exp 0 0b", done8, result8);
        end
    endtask

    initial begin
        test_reset();
        test_add_sub();
        test_logic_shift();
        test_mul();
        test_reset_mid_mul();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
